fpu_dispatch: RTL

- Requester side of the fixed-latency FPU units (fdiv, fmul).
- Accepts decoded FP ops from the core over a valid/ready handshake and launches operands into the selected unit.
- Tracks in-flight ops and reserves the single writeback slot; returns tagged results to the FP register file.
- Detects RAW/WAW hazards via a 32-entry busy scoreboard and stalls issue when needed.

---
 rtl/fpu_dispatch_if.sv | 27 ++
 rtl/fpu_dispatch.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fpu_dispatch_if.sv
// Core-facing bundle of fpu_dispatch: the op issue handshake, the writeback
// port and the busy scoreboard.
interface fpu_dispatch_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ovf;
  logic [31:0] busy;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_a, in_b,
    input  in_ready, wb_valid, wb_rd, wb_data, wb_ovf, busy
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_a, in_b,
    output in_ready, wb_valid, wb_rd, wb_data, wb_ovf, busy
  );
endinterface

// File: rtl/fpu_dispatch.sv
// Issues FP ops to fixed-latency fdiv/fmul units, reserves the single writeback
// slot and tracks destinations in a busy scoreboard. Option: FPU_OVF_STICKY_EN.
module fpu_dispatch #(
  parameter int DIV_LAT = 4,
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rstn,
  fpu_dispatch_if.slave bus,
  output logic [31:0] div_x1,
  output logic [31:0] div_x2,
  input  logic [31:0] div_y,
  input  logic        div_ovf,
  output logic [31:0] mul_x1,
  output logic [31:0] mul_x2,
  input  logic [31:0] mul_y,
  input  logic        mul_ovf,
  output logic        ovf_sticky,
  input  logic        ovf_clr
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int RESV_W  = MAX_LAT + 2;
  localparam int IDX_W   = $clog2(RESV_W);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } tag_t;

  tag_t div_tags [DIV_LAT+1];
  tag_t mul_tags [MUL_LAT+1];

  // resv[k] set: the writeback slot k+1 cycles from now is taken.
  logic [RESV_W-1:0] resv;
  logic [RESV_W-1:0] resv_next;
  logic [IDX_W-1:0]  slot_idx;
  logic [31:0]       busy_next;
  logic              accept;

  assign slot_idx      = bus.in_op ? IDX_W'(DIV_LAT + 1) : IDX_W'(MUL_LAT + 1);
  assign bus.in_ready  = !bus.busy[bus.in_rs1] && !bus.busy[bus.in_rs2] &&
                         !bus.busy[bus.in_rd] && !resv[slot_idx];
  assign accept        = bus.in_valid && bus.in_ready;

  // NOTE: every variable gets a default at the top of an always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    resv_next = resv >> 1;
    if (accept) resv_next[slot_idx - IDX_W'(1)] = 1'b1;
    busy_next = bus.busy;
    if (bus.wb_valid) busy_next[bus.wb_rd] = 1'b0;
    if (accept)       busy_next[bus.in_rd] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order within or across blocks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resv     <= '0;
      bus.busy <= '0;
      div_x1   <= '0;
      div_x2   <= '0;
      mul_x1   <= '0;
      mul_x2   <= '0;
    end else begin
      resv     <= resv_next;
      bus.busy <= busy_next;
      if (accept && bus.in_op) begin
        div_x1 <= bus.in_a;
        div_x2 <= bus.in_b;
      end
      if (accept && !bus.in_op) begin
        mul_x1 <= bus.in_a;
        mul_x2 <= bus.in_b;
      end
    end
  end

  // NOTE: the tag pipelines are reset despite being array storage because
  // their valid bits are what drop in-flight ops across a reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i <= DIV_LAT; i++) div_tags[i] <= '0;
      for (int i = 0; i <= MUL_LAT; i++) mul_tags[i] <= '0;
    end else begin
      div_tags[0] <= '{valid: accept && bus.in_op, rd: bus.in_rd};
      mul_tags[0] <= '{valid: accept && !bus.in_op, rd: bus.in_rd};
      for (int i = 1; i <= DIV_LAT; i++) div_tags[i] <= div_tags[i-1];
      for (int i = 1; i <= MUL_LAT; i++) mul_tags[i] <= mul_tags[i-1];
    end
  end

  // The last tag stage lines up with the cycle in which the unit's y is valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.wb_valid <= 1'b0;
      bus.wb_rd    <= '0;
      bus.wb_data  <= '0;
      bus.wb_ovf   <= 1'b0;
    end else if (div_tags[DIV_LAT].valid) begin
      bus.wb_valid <= 1'b1;
      bus.wb_rd    <= div_tags[DIV_LAT].rd;
      bus.wb_data  <= div_y;
      bus.wb_ovf   <= div_ovf;
    end else if (mul_tags[MUL_LAT].valid) begin
      bus.wb_valid <= 1'b1;
      bus.wb_rd    <= mul_tags[MUL_LAT].rd;
      bus.wb_data  <= mul_y;
      bus.wb_ovf   <= mul_ovf;
    end else begin
      bus.wb_valid <= 1'b0;
      bus.wb_ovf   <= 1'b0;
    end
  end

`ifdef FPU_OVF_STICKY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                            ovf_sticky <= 1'b0;
    else if (bus.wb_valid && bus.wb_ovf)  ovf_sticky <= 1'b1;
    else if (ovf_clr)                     ovf_sticky <= 1'b0;
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky     = 1'b0;
`endif

endmodule
